instruction_fetch: RTL
======================

# instruction_fetch

Front-end fetch stage that sits directly upstream of the byte-addressed `Memory` block. It owns the program counter and drives `pcAddress` to the memory instruction port. It captures each returned word together with its PC in a small prefetch FIFO and hands instructions to decode over a valid/ready handshake. Branch and jump redirects flush the FIFO, and a redirect to a misaligned target halts fetch with a fault flag.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `FIFO_DEPTH`, default `2`: prefetch entries; must be a power of two, ≥2.
- `clk` in 1: sole clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pcAddress` out 32: fetch address to `Memory`. Memory decodes bits [15:0] only.
- `pcDataOutput` in 32: instruction word from `Memory`, valid combinationally in the same cycle.
- `redirectValid` in 1: taken branch or jump from downstream.
- `redirectTarget` in 32: new PC. Sampled only when `redirectValid` is high.
- `instrValid` out 1: FIFO head holds an instruction.
- `instrReady` in 1: decode accepts the head.
- `instr` out 32: head instruction word. Zero when `instrValid` is low.
- `instrPc` out 32: PC of the head instruction. Zero when `instrValid` is low.
- `misalignFault` out 1: fetch halted on a misaligned redirect.
- `faultAddress` out 32: offending target. Zero unless `misalignFault` is high.

## Operation
- Registers: `fetchPc` (32), FIFO storage of `{pc, word}` pairs, `count`, state.
- Combinational drive: `pcAddress = fetchPc` in both states.
- States:
  - `FETCH`: normal operation.
  - `FAULT`: `misalignFault` = 1; no pushes; FIFO is empty.
- Pop: occurs when `instrValid && instrReady`.
- Push, in `FETCH` without a redirect: occurs when `count < FIFO_DEPTH`, or when the FIFO is full and a pop happens in the same cycle.
  - A push writes `{fetchPc, pcDataOutput}`.
  - A push advances `fetchPc` by 4, wrapping mod 2^32.
  - When the FIFO is full with no pop, there is no push and `fetchPc` holds.
- Redirect, which has the highest priority:
  - The FIFO is flushed to `count` = 0. Any pop in the same cycle still counts as accepted by decode.
  - No push occurs in the redirect cycle.
  - If `redirectTarget[1:0] == 0`: `fetchPc` ← target and state ← `FETCH`.
  - Otherwise: state ← `FAULT`, `faultAddress` ← target, and `fetchPc` ← target so that `pcAddress` shows it.
- `FAULT` → `FETCH` only on an aligned redirect or on reset. A misaligned redirect while in `FAULT` updates `faultAddress`.
- `fetchPc` is always word-aligned in `FETCH`. Addresses above 16 bits alias within memory; this is not an error.
- Simultaneous push and pop: `count` is unchanged, and the head advances to the next entry.

## Timing
- Reset values: `fetchPc` = `RESET_PC`, so `pcAddress` = `RESET_PC`. `instrValid` = 0, `instr` = 0, `instrPc` = 0, `misalignFault` = 0, `faultAddress` = 0, state `FETCH`, `count` = 0.
- Reset asserted mid-operation clears everything above immediately, with no clock edge required. In-flight instructions are discarded.
- First edge after reset release: pushes the word at `RESET_PC`. `instrValid` rises in the following cycle.
- Fetch-to-valid latency: 1 cycle. A word fetched in cycle N is at the head in N+1 if the FIFO was empty.
- Redirect in cycle N:
  - N+1: `instrValid` = 0 and `pcAddress` = target.
  - N+2: `instrValid` = 1 with `instrPc` = target.
- Redirect penalty: 2 cycles.
- Throughput: 1 instruction per cycle while `instrReady` is held high.
- Outputs are stable within a cycle. `instrValid` does not drop without a pop, redirect, or reset.
- `misalignFault` rises in the cycle after the misaligned redirect.

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum (`FETCH`, `FAULT`).
  - `INSTR_BYTES = 4`.
  - `DEFAULT_RESET_PC`.
  - Shared with the decode stage and the top level.
- Sub-module `fetch_fifo`: synchronous FIFO with flush, push, pop, and full/empty outputs; width 64. Parameterised by depth; head outputs are read combinationally from registers.
- `instruction_fetch` holds the PC register, the state machine, and the push/redirect priority logic.

## Test plan
- Reset release, `instrReady` = 1, memory words at 0x0/0x4/0x8 = 0x11111111/0x22222222/0x33333333 → consecutive cycles show `instrPc` 0x0/0x4/0x8 with the matching `instr`, one per cycle.
- `instrReady` = 0 for 5 cycles → after 2 pushes `pcAddress` holds at 0x8 and `instrPc` holds 0x0. Raising `instrReady` drains 0x0, 0x4, 0x8 with no gaps.
- `redirectValid` with target 0x100 while the FIFO is full → next cycle `instrValid` = 0; the cycle after, `instrPc` = 0x100. Entries 0x4 and 0x8 never appear.
- Redirect to 0x102 → `misalignFault` = 1, `faultAddress` = 0x102, `instrValid` stays 0. A subsequent redirect to 0x200 clears the fault, and `instrPc` = 0x200 two cycles later.
- `rst` asserted between clock edges with 2 entries buffered → `instrValid` = 0 and `pcAddress` = `RESET_PC` immediately. Fetch resumes at `RESET_PC` after release.
- Wrap: redirect to 0xFFFFFFFC → next `instrPc` values are 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants (fetch, decode, top level).
package cpu_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch stage control state
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // Prefetch FIFO payload: instruction word tagged with its PC
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, word} entries with flush; head read combinationally from registers.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    fetch_entry_t  mem_q [DEPTH];

    // Pointer and occupancy update; flush dominates push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until counted as valid
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, prefetches into a small FIFO, handles redirects and misalign faults.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pcAddress,
    input  logic [31:0] pcDataOutput,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    output logic        misalignFault,
    output logic [31:0] faultAddress
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  fault_addr_q, fault_addr_d;

    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t fifo_head;
    fetch_entry_t fifo_wdata;

    assign instrValid = !fifo_empty;
    assign pop        = instrValid && instrReady;
    assign fifo_wdata = '{pc: fetch_pc_q, word: pcDataOutput};

    // Next-state, PC and push decision; a redirect overrides fetching
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        fault_addr_d = fault_addr_q;
        push         = 1'b0;
        if (redirectValid) begin
            fetch_pc_d = redirectTarget;
            if (redirectTarget[1:0] == 2'b00) begin
                state_d      = FETCH;
                fault_addr_d = '0;
            end else begin
                state_d      = FAULT;
                fault_addr_d = redirectTarget;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (!fifo_full || pop) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
                    end
                end
                FAULT: begin
                    push = 1'b0;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // State, PC and fault-address registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirectValid),
        .push_i      (push),
        .push_data_i (fifo_wdata),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign pcAddress     = fetch_pc_q;
    assign instr         = instrValid ? fifo_head.word : '0;
    assign instrPc       = instrValid ? fifo_head.pc   : '0;
    assign misalignFault = (state_q == FAULT);
    assign faultAddress  = fault_addr_q;

endmodule
